// File: rtl/lpc_host.sv
// LPC host for TPM locality cycles: drives one I/O read/write frame on LAD/LFRAME#.
// Latency: 13 cycles accept-to-done with zero wait states, +1 per SYNC wait cycle.
// Backpressure: start is accepted only while busy=0 (never in the done cycle); no queueing.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   start/write/addr/wdata   request, captured in the accept cycle (start=1, busy=0)
//   busy, done, error, rdata status; done is a one-cycle pulse, error/rdata valid with done
//   frame, outAd, enable     LFRAME# (active low), LAD drive value and LAD output enable
//   inAd                     LAD as seen on the bus (sampled during SYNC and read data)
module lpc_host #(
  parameter int unsigned SYNC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  rdata,
  output logic        frame,
  output logic [3:0]  outAd,
  output logic        enable,
  input  logic [3:0]  inAd
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CTDIR,
    ST_ADDR,
    ST_WDATA,
    ST_TAR_H,
    ST_SYNC,
    ST_RDATA,
    ST_TAR_P,
    ST_ABORT
  } state_t;

  localparam logic [3:0] LAD_IDLE   = 4'b1111;
  localparam logic [3:0] LAD_START  = 4'b0101;
  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_ERROR = 4'b1010;
  // Value of the SYNC counter on the last SYNC cycle allowed before aborting.
  localparam logic [7:0] SYNC_LAST  = 8'(SYNC_TIMEOUT - 1);

  state_t      state;
  logic [1:0]  ph;         // cycle index inside multi-cycle states
  logic [7:0]  sync_cnt;   // consecutive SYNC wait cycles seen so far
  logic        wr_q;
  logic [15:0] addr_q;     // shifted left one nibble per address cycle
  logic [7:0]  wdata_q;

  // Every output is registered: each branch loads the bus values for the
  // state being entered, so they appear in the same cycle as that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ph       <= 2'd0;
      sync_cnt <= 8'd0;
      wr_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      rdata    <= 8'h00;
      frame    <= 1'b1;
      enable   <= 1'b0;
      outAd    <= LAD_IDLE;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          frame  <= 1'b1;
          enable <= 1'b0;
          outAd  <= LAD_IDLE;
          if (start) begin
            wr_q    <= write;
            addr_q  <= addr;
            wdata_q <= wdata;
            error   <= 1'b0;
            busy    <= 1'b1;
            frame   <= 1'b0;
            enable  <= 1'b1;
            outAd   <= LAD_START;
            state   <= ST_START;
          end
        end

        ST_START: begin
          frame <= 1'b1;
          outAd <= {2'b00, wr_q, 1'b0};
          state <= ST_CTDIR;
        end

        ST_CTDIR: begin
          outAd  <= addr_q[15:12];
          addr_q <= {addr_q[11:0], 4'h0};
          ph     <= 2'd0;
          state  <= ST_ADDR;
        end

        ST_ADDR: begin
          if (ph == 2'd3) begin
            ph <= 2'd0;
            if (wr_q) begin
              outAd <= wdata_q[3:0];
              state <= ST_WDATA;
            end else begin
              outAd <= LAD_IDLE;
              state <= ST_TAR_H;
            end
          end else begin
            ph     <= ph + 2'd1;
            outAd  <= addr_q[15:12];
            addr_q <= {addr_q[11:0], 4'h0};
          end
        end

        ST_WDATA: begin
          if (ph == 2'd0) begin
            ph    <= 2'd1;
            outAd <= wdata_q[7:4];
          end else begin
            ph    <= 2'd0;
            outAd <= LAD_IDLE;
            state <= ST_TAR_H;
          end
        end

        // First turnaround cycle drives 1111, second releases the bus.
        ST_TAR_H: begin
          if (ph == 2'd0) begin
            ph     <= 2'd1;
            enable <= 1'b0;
          end else begin
            ph       <= 2'd0;
            sync_cnt <= 8'd0;
            state    <= ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (inAd == SYNC_READY || inAd == SYNC_ERROR) begin
            error    <= (inAd == SYNC_ERROR);
            ph       <= 2'd0;
            sync_cnt <= 8'd0;
            state    <= wr_q ? ST_TAR_P : ST_RDATA;
          end else if (sync_cnt == SYNC_LAST) begin
            // Peripheral never answered: claim the bus back with LFRAME#.
            frame    <= 1'b0;
            enable   <= 1'b1;
            outAd    <= LAD_IDLE;
            ph       <= 2'd0;
            sync_cnt <= 8'd0;
            state    <= ST_ABORT;
          end else if (sync_cnt != 8'hFF) begin
            sync_cnt <= sync_cnt + 8'd1;
          end
        end

        // Data is taken even after an error SYNC; error travels separately.
        ST_RDATA: begin
          if (ph == 2'd0) begin
            ph         <= 2'd1;
            rdata[3:0] <= inAd;
          end else begin
            ph         <= 2'd0;
            rdata[7:4] <= inAd;
            state      <= ST_TAR_P;
          end
        end

        ST_TAR_P: begin
          if (ph == 2'd0) begin
            ph   <= 2'd1;
            done <= 1'b1;
          end else begin
            ph    <= 2'd0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_ABORT: begin
          ph <= ph + 2'd1;
          if (ph == 2'd2) begin
            done  <= 1'b1;
            error <= 1'b1;
          end
          if (ph == 2'd3) begin
            ph     <= 2'd0;
            frame  <= 1'b1;
            enable <= 1'b0;
            outAd  <= LAD_IDLE;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: begin
          ph    <= 2'd0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: stimulus builds, from the protocol rules, the expected bus
// trace per cycle and the expected response per transaction; a monitor on the
// falling edge pops and compares both.
module tb_lpc_host;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        write;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [3:0]  inAd;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  rdata;
  logic        frame;
  logic [3:0]  outAd;
  logic        enable;

  lpc_host #(.SYNC_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .start(start), .write(write), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .error(error), .rdata(rdata),
    .frame(frame), .outAd(outAd), .enable(enable), .inAd(inAd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       frame;
    logic       enable;
    logic       busy;
    logic       done;
    logic [3:0] ad;
    bit         chk_ad;
    bit         chk_re;
    logic       err;
    logic [7:0] rd;
  } bus_t;

  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] rd;
  } resp_t;

  bus_t  bq[$];
  resp_t rq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic [7:0] m_rdata;   // reference copy of the read-data register
  bus_t  me;
  resp_t mr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bus_t ent(input logic f, input logic e, input logic b, input logic d,
                               input logic [3:0] ad, input bit ca);
    bus_t r;
    r.frame = f; r.enable = e; r.busy = b; r.done = d; r.ad = ad;
    r.chk_ad = ca; r.chk_re = 1'b0; r.err = 1'b0; r.rd = 8'h00;
    return r;
  endfunction

  function automatic bus_t rst_ent();
    bus_t r;
    r = ent(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1);
    r.chk_re = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] wait_nib();
    logic [3:0] v;
    do v = 4'($urandom_range(0, 15)); while (v == 4'h0 || v == 4'hA);
    return v;
  endfunction

  // Monitor: per-cycle bus trace plus one response per done pulse.
  always @(negedge clk) begin
    if (bq.size() > 0) begin
      me = bq.pop_front();
      chk("frame", 32'(frame), 32'(me.frame));
      chk("enable", 32'(enable), 32'(me.enable));
      chk("busy", 32'(busy), 32'(me.busy));
      chk("done", 32'(done), 32'(me.done));
      if (me.chk_ad) chk("outAd", 32'(outAd), 32'(me.ad));
      if (me.chk_re) begin
        chk("error_reset", 32'(error), 32'(me.err));
        chk("rdata_reset", 32'(rdata), 32'(me.rd));
      end
    end
    if (done === 1'b1) begin
      if (rq.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        mr = rq.pop_front();
        chk("done_cycle", 32'(cyc), 32'(mr.cyc));
        chk("error", 32'(error), 32'(mr.err));
        chk("rdata", 32'(rdata), 32'(mr.rd));
      end
    end
  end

  // kind: 0 = ready SYNC, 1 = error SYNC, 2 = no answer (timeout).
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] wd,
                         input int kind, input int nwait, input logic [3:0] wv,
                         input bit rnd_wv, input logic [7:0] data, input int gap);
    bus_t       tr[$];
    logic [3:0] sch[$];
    resp_t      r;
    int         nsync;
    int         c0;

    tr.push_back(ent(1'b0, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b1));
    tr.push_back(ent(1'b1, 1'b1, 1'b1, 1'b0, {2'b00, w, 1'b0}, 1'b1));
    for (int i = 0; i < 4; i++) tr.push_back(ent(1'b1, 1'b1, 1'b1, 1'b0, a[15-4*i -: 4], 1'b1));
    if (w) begin
      tr.push_back(ent(1'b1, 1'b1, 1'b1, 1'b0, wd[3:0], 1'b1));
      tr.push_back(ent(1'b1, 1'b1, 1'b1, 1'b0, wd[7:4], 1'b1));
    end
    tr.push_back(ent(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1));
    tr.push_back(ent(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0));
    for (int i = 0; i < tr.size(); i++) sch.push_back(4'($urandom_range(0, 15)));

    nsync = (kind == 2) ? T : nwait + 1;
    for (int k = 0; k < nsync; k++) begin
      tr.push_back(ent(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0));
      if (kind != 2 && k == nsync - 1) sch.push_back((kind == 1) ? 4'hA : 4'h0);
      else sch.push_back(rnd_wv ? wait_nib() : wv);
    end

    if (kind == 2) begin
      for (int k = 0; k < 4; k++) begin
        tr.push_back(ent(1'b0, 1'b1, 1'b1, 1'(k == 3), 4'hF, 1'b1));
        sch.push_back(4'($urandom_range(0, 15)));
      end
      r.err = 1'b1;
    end else begin
      if (!w) begin
        tr.push_back(ent(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0));
        tr.push_back(ent(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0));
        sch.push_back(data[3:0]);
        sch.push_back(data[7:4]);
        m_rdata = data;
      end
      tr.push_back(ent(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0));
      tr.push_back(ent(1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0));
      sch.push_back(4'($urandom_range(0, 15)));
      sch.push_back(4'($urandom_range(0, 15)));
      r.err = 1'(kind == 1);
    end
    r.rd = m_rdata;

    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      write = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
      bq.push_back(ent(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1));
    end

    @(posedge clk); #1;
    reset = 1'b0; start = 1'b1; write = w; addr = a; wdata = wd;
    inAd = 4'($urandom_range(0, 15));
    bq.push_back(ent(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1));
    c0 = cyc;
    r.cyc = c0 + tr.size();
    rq.push_back(r);

    // Requests during the transaction, including in the done cycle, must be ignored.
    for (int j = 0; j < tr.size(); j++) begin
      @(posedge clk); #1;
      start = (j == tr.size() - 1) ? 1'b1 : 1'($urandom);
      write = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
      inAd  = sch[j];
      bq.push_back(tr[j]);
    end
  endtask

  // Reset in the middle of the address phase with start held high.
  task automatic reset_mid_addr();
    @(posedge clk); #1;
    start = 1'b1; write = 1'b1; addr = 16'h1234; wdata = 8'h77;
    bq.push_back(ent(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1));
    @(posedge clk); #1;
    bq.push_back(ent(1'b0, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b1));
    @(posedge clk); #1;
    bq.push_back(ent(1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1));
    @(posedge clk); #1;
    bq.push_back(ent(1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 1'b1));
    @(posedge clk); #1;
    reset = 1'b1;
    m_rdata = 8'h00;
    bq.push_back(rst_ent());
    @(posedge clk); #1;
    bq.push_back(rst_ent());
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; write = 1'b0; addr = 16'h0; wdata = 8'h0; inAd = 4'hF;
    m_rdata = 8'h00;
    repeat (3) begin
      @(posedge clk); #1;
      bq.push_back(rst_ent());
    end

    run_txn(1'b1, 16'h0F00, 8'hA5, 0, 0, 4'h0, 1'b0, 8'h00, 0);
    run_txn(1'b0, 16'h0F18, 8'h00, 0, 0, 4'h0, 1'b0, 8'hC3, 0);
    run_txn(1'b0, 16'h0F24, 8'h00, 0, 3, 4'b0110, 1'b0, 8'h96, 1);
    run_txn(1'b1, 16'h0F30, 8'h3C, 2, 0, 4'hF, 1'b0, 8'h00, 0);
    run_txn(1'b0, 16'h0F00, 8'h00, 1, 0, 4'h0, 1'b0, 8'h5A, 0);
    run_txn(1'b0, 16'h0F04, 8'h00, 2, 0, 4'hF, 1'b1, 8'hEE, 2);

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
      run_txn(1'($urandom), 16'($urandom), 8'($urandom), kind,
              int'($urandom_range(0, 5)), 4'h0, 1'b1, 8'($urandom),
              int'($urandom_range(0, 2)));
    end

    reset_mid_addr();
    run_txn(1'b0, 16'h0F18, 8'h00, 0, 1, 4'h0, 1'b1, 8'h3D, 0);
    run_txn(1'b1, 16'hABCD, 8'h81, 1, 2, 4'h0, 1'b1, 8'h00, 0);

    repeat (3) begin
      @(posedge clk); #1;
      start = 1'b0;
      bq.push_back(ent(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1));
    end
    @(negedge clk); #1;
    chk("pending_responses", 32'(rq.size()), 32'd0);
    chk("pending_trace", 32'(bq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
